// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle for the fetch controller: redirect input, byte-wide imem read port,
// and the decoded-instruction valid/ready handshake towards decode.
interface imem_fetch_ctrl_if #(
  parameter int unsigned DATA_WID = 64
) ();
  logic                pc_load;
  logic [DATA_WID-1:0] load_pc;
  logic                mem_rd_en;
  logic [DATA_WID-1:0] mem_addr;
  logic [7:0]          mem_rdata;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [3:0]          rA;
  logic [3:0]          rB;
  logic [DATA_WID-1:0] valC;
  logic [DATA_WID-1:0] valP;
  logic                instr_invalid;
  logic                imem_error;
  logic                halted;

  modport master (
    input  pc_load, load_pc, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_invalid, imem_error, halted
  );

  modport slave (
    output pc_load, load_pc, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_invalid, imem_error, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Y86-64 fetch sequencer: reads one instruction byte per cycle from a synchronous imem,
// assembles icode/ifun/rA/rB/valC/valP and hands them to decode over valid/ready.
module imem_fetch_ctrl #(
  parameter int unsigned DATA_WID  = 64,
  parameter int unsigned MEM_DEPTH = 2048
) (
  input logic               clk,
  input logic               rst_n,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StOut, StHalt} state_e;

  localparam logic [DATA_WID:0] MemDepthExt = (DATA_WID+1)'(MEM_DEPTH);

  state_e              r_state;
  logic [DATA_WID-1:0] r_pc;
  logic [DATA_WID-1:0] r_mem_addr;
  logic [DATA_WID-1:0] r_valc;
  logic [DATA_WID-1:0] r_valp;
  logic                r_mem_rd_en;
  logic                r_out_valid;
  logic                r_invalid;
  logic                r_err;
  logic                r_halted;
  logic [3:0]          r_icode;
  logic [3:0]          r_ifun;
  logic [3:0]          r_ra;
  logic [3:0]          r_rb;
  logic [3:0]          r_idx;        // bytes issued so far
  logic [3:0]          r_rcv;        // bytes received so far
  logic [3:0]          r_len;
  logic                r_len_known;
  logic                r_pend;       // read data for byte r_rcv arrives this cycle

  logic                w_byte0;
  logic                w_len_final;
  logic [3:0]          w_len;
  logic [3:0]          w_rcv_next;
  logic                w_done;
  logic                w_want;
  logic [DATA_WID:0]   w_addr_ext;
  logic                w_addr_ok;
  logic                w_cbyte;
  logic [2:0]          w_cidx;
  logic [DATA_WID-1:0] w_cdata;
  logic                w_hs;
  logic                w_stop;
  logic                w_start;
  logic [DATA_WID-1:0] w_start_pc;
  logic                w_start_ok;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  always_comb begin
    w_byte0     = r_pend && (r_rcv == 4'd0);
    w_len_final = r_len_known || w_byte0;
    if (r_len_known) begin
      w_len = r_len;
    end else if (w_byte0) begin
      w_len = instr_len(bus.mem_rdata[7:4]);
    end else begin
      w_len = 4'd2;  // speculative: byte 1 may be issued before byte 0 returns
    end
    w_rcv_next = r_rcv + {3'd0, r_pend};
    w_done     = w_len_final && (w_rcv_next >= w_len);
    w_want     = r_idx < w_len;
    w_addr_ext = {1'b0, r_pc} + {{(DATA_WID-3){1'b0}}, r_idx};
    w_addr_ok  = w_addr_ext < MemDepthExt;

    w_cbyte = 1'b0;
    w_cidx  = 3'd0;
    if (r_icode == 4'h7 || r_icode == 4'h8) begin
      w_cbyte = (r_rcv >= 4'd1) && (r_rcv <= 4'd8);
      w_cidx  = 3'(r_rcv - 4'd1);
    end else if (r_icode == 4'h3 || r_icode == 4'h4 || r_icode == 4'h5) begin
      w_cbyte = (r_rcv >= 4'd2) && (r_rcv <= 4'd9);
      w_cidx  = 3'(r_rcv - 4'd2);
    end
    w_cdata = DATA_WID'(bus.mem_rdata) << {w_cidx, 3'b000};

    w_hs       = r_out_valid && bus.out_ready;
    w_stop     = (r_icode == 4'h0) || r_invalid || r_err;
    w_start    = bus.pc_load || (r_state == StIdle) || ((r_state == StOut) && w_hs && !w_stop);
    w_start_pc = bus.pc_load ? bus.load_pc : ((r_state == StIdle) ? r_pc : r_valp);
    w_start_ok = {1'b0, w_start_pc} < MemDepthExt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pc        <= '0;
      r_mem_addr  <= '0;
      r_valc      <= '0;
      r_valp      <= '0;
      r_mem_rd_en <= 1'b0;
      r_out_valid <= 1'b0;
      r_invalid   <= 1'b0;
      r_err       <= 1'b0;
      r_halted    <= 1'b0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= 4'hF;
      r_rb        <= 4'hF;
      r_idx       <= 4'd0;
      r_rcv       <= 4'd0;
      r_len       <= 4'd0;
      r_len_known <= 1'b0;
      r_pend      <= 1'b0;
    end else if (w_start) begin
      // Byte 0 of the new fetch is issued on the same edge; in-flight data is dropped.
      r_state     <= StFetch;
      r_pc        <= w_start_pc;
      r_mem_rd_en <= w_start_ok;
      r_mem_addr  <= w_start_pc;
      r_idx       <= w_start_ok ? 4'd1 : 4'd0;
      r_rcv       <= 4'd0;
      r_pend      <= 1'b0;
      r_len       <= 4'd0;
      r_len_known <= 1'b0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_invalid   <= 1'b0;
      r_err       <= 1'b0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= 4'hF;
      r_rb        <= 4'hF;
      r_valc      <= '0;
      r_valp      <= '0;
    end else begin
      unique case (r_state)
        StFetch: begin
          r_mem_rd_en <= 1'b0;
          r_pend      <= r_mem_rd_en;
          if (r_pend) begin
            r_rcv <= w_rcv_next;
            if (w_byte0) begin
              r_icode     <= bus.mem_rdata[7:4];
              r_ifun      <= bus.mem_rdata[3:0];
              r_len       <= w_len;
              r_len_known <= 1'b1;
              r_invalid   <= bus.mem_rdata[7:4] > 4'hB;
            end
            if (r_rcv == 4'd1 && (r_len == 4'd2 || r_len == 4'd10)) begin
              r_ra <= bus.mem_rdata[7:4];
              r_rb <= bus.mem_rdata[3:0];
            end
            if (w_cbyte) begin
              r_valc <= r_valc | w_cdata;
            end
          end
          if (w_done) begin
            r_state     <= StOut;
            r_out_valid <= 1'b1;
            r_valp      <= r_pc + DATA_WID'(w_len);
          end else if (w_want && w_addr_ok) begin
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= w_addr_ext[DATA_WID-1:0];
            r_idx       <= r_idx + 4'd1;
          end else if (w_want && (w_len_final || r_idx == 4'd0)) begin
            // A needed byte lies beyond the memory: report an error instruction.
            r_state     <= StOut;
            r_out_valid <= 1'b1;
            r_err       <= 1'b1;
            r_invalid   <= 1'b0;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= 4'hF;
            r_rb        <= 4'hF;
            r_valc      <= '0;
            r_valp      <= r_pc;
          end
        end
        StOut: begin
          r_mem_rd_en <= 1'b0;
          r_pend      <= 1'b0;
          if (w_hs) begin
            r_state     <= StHalt;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b1;
          end
        end
        StHalt: begin
          r_mem_rd_en <= 1'b0;
          r_pend      <= 1'b0;
        end
        StIdle: begin
          r_mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd_en     = r_mem_rd_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.out_valid     = r_out_valid;
  assign bus.icode         = r_icode;
  assign bus.ifun          = r_ifun;
  assign bus.rA            = r_ra;
  assign bus.rB            = r_rb;
  assign bus.valC          = r_valc;
  assign bus.valP          = r_valp;
  assign bus.instr_invalid = r_invalid;
  assign bus.imem_error    = r_err;
  assign bus.halted        = r_halted;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: byte-wide synchronous memory model plus
// per-scenario tasks with hand-computed expectations.
module tb_imem_fetch_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  imem_fetch_ctrl_if #(.DATA_WID(64)) bus ();

  imem_fetch_ctrl #(
    .DATA_WID (64),
    .MEM_DEPTH(2048)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  int n_chk    = 0;
  int n_err    = 0;
  int n_strobe = 0;
  int n_oor    = 0;
  bit seen_2047 = 1'b0;

  // Synchronous memory: data for a strobe appears the following cycle.
  always @(posedge clk) begin
    if (bus.mem_rd_en === 1'b1) begin
      n_strobe++;
      if (bus.mem_addr >= 64'd2048) n_oor++;
      else bus.mem_rdata <= mem[bus.mem_addr[10:0]];
      if (bus.mem_addr == 64'd2047) seen_2047 = 1'b1;
    end
  end

  task automatic wait_valid(output int n);
    int i;
    i = 0;
    n = -1;
    while (n < 0 && i < 40) begin
      @(negedge clk);
      i++;
      if (bus.out_valid === 1'b1) n = i;
    end
  endtask

  task automatic redirect(input logic [63:0] a);
    bus.pc_load = 1'b1;
    bus.load_pc = a;
    @(negedge clk);
    bus.pc_load = 1'b0;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus.mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.mem_rd_en); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_chk++; if ({bus.rA, bus.rB} !== 8'hFF) begin n_err++; $display("FAIL reset_regs: got %h want ff", {bus.rA, bus.rB}); end
    n_chk++; if ({bus.icode, bus.ifun, bus.halted, bus.imem_error, bus.instr_invalid} !== 11'd0) begin
      n_err++; $display("FAIL reset_flags: got %h want 0", {bus.icode, bus.ifun, bus.halted, bus.imem_error, bus.instr_invalid}); end
    n_chk++; if ({bus.valC, bus.valP} !== 128'd0) begin n_err++; $display("FAIL reset_vals: got %h want 0", {bus.valC, bus.valP}); end
    n_chk++; if (n_strobe !== 0) begin n_err++; $display("FAIL reset_strobes: got %0d want 0", n_strobe); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_irmovq();
    int n;
    n_chk++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL irmovq_first_issue: got %b/%h want 1/0", bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if (n !== 11) begin n_err++; $display("FAIL irmovq_latency: got %0d want 11", n); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB} !== 16'h30F4) begin n_err++; $display("FAIL irmovq_fields: got %h want 30f4", {bus.icode, bus.ifun, bus.rA, bus.rB}); end
    n_chk++; if (bus.valC !== 64'h123) begin n_err++; $display("FAIL irmovq_valC: got %h want 123", bus.valC); end
    n_chk++; if (bus.valP !== 64'd10) begin n_err++; $display("FAIL irmovq_valP: got %h want a", bus.valP); end
    n_chk++; if ({bus.instr_invalid, bus.imem_error} !== 2'b00) begin n_err++; $display("FAIL irmovq_flags: got %b want 00", {bus.instr_invalid, bus.imem_error}); end
  endtask

  task automatic test_jmp_addq();
    int n;
    redirect(64'h20);
    n_chk++; if ({bus.out_valid, bus.mem_rd_en, bus.mem_addr} !== {2'b01, 64'h20}) begin n_err++; $display("FAIL jmp_redirect: got %b%b/%h want 01/20", bus.out_valid, bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if (n !== 10) begin n_err++; $display("FAIL jmp_latency: got %0d want 10", n); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB} !== 16'h70FF) begin n_err++; $display("FAIL jmp_fields: got %h want 70ff", {bus.icode, bus.ifun, bus.rA, bus.rB}); end
    n_chk++; if ({bus.valC, bus.valP} !== {64'h100, 64'h29}) begin n_err++; $display("FAIL jmp_vals: got %h/%h want 100/29", bus.valC, bus.valP); end
    accept();
    n_chk++; if ({bus.out_valid, bus.mem_rd_en, bus.mem_addr} !== {2'b01, 64'h29}) begin n_err++; $display("FAIL addq_no_bubble: got %b%b/%h want 01/29", bus.out_valid, bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if (n !== 3) begin n_err++; $display("FAIL addq_latency: got %0d want 3", n); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB} !== 16'h6023) begin n_err++; $display("FAIL addq_fields: got %h want 6023", {bus.icode, bus.ifun, bus.rA, bus.rB}); end
    n_chk++; if ({bus.valC, bus.valP} !== {64'h0, 64'h2B}) begin n_err++; $display("FAIL addq_vals: got %h/%h want 0/2b", bus.valC, bus.valP); end
  endtask

  task automatic test_backpressure();
    int n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.out_valid, bus.mem_rd_en, bus.icode, bus.rA, bus.rB, bus.valP} !== {2'b10, 12'h623, 64'h2B}) begin
        n_err++; $display("FAIL stall_hold_%0d: got %b%b %h%h%h %h want 10 623 2b", i, bus.out_valid, bus.mem_rd_en, bus.icode, bus.rA, bus.rB, bus.valP);
      end
    end
    accept();
    n_chk++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 64'h2B}) begin n_err++; $display("FAIL stall_release_issue: got %b/%h want 1/2b", bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if (n !== 2) begin n_err++; $display("FAIL nop_latency: got %0d want 2", n); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB, bus.valP} !== {16'h10FF, 64'h2C}) begin
      n_err++; $display("FAIL nop_fields: got %h%h%h%h/%h want 10ff/2c", bus.icode, bus.ifun, bus.rA, bus.rB, bus.valP); end
  endtask

  task automatic test_halt();
    int n;
    int s;
    redirect(64'd5);
    wait_valid(n);
    n_chk++; if (n !== 2) begin n_err++; $display("FAIL halt_latency: got %0d want 2", n); end
    n_chk++; if ({bus.icode, bus.valP} !== {4'h0, 64'd6}) begin n_err++; $display("FAIL halt_fields: got %h/%h want 0/6", bus.icode, bus.valP); end
    accept();
    n_chk++; if ({bus.halted, bus.out_valid, bus.mem_rd_en} !== 3'b100) begin n_err++; $display("FAIL halt_state: got %b want 100", {bus.halted, bus.out_valid, bus.mem_rd_en}); end
    s = n_strobe;
    repeat (5) @(negedge clk);
    n_chk++; if (n_strobe !== s || bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_quiet: got %0d strobes halted=%b want 0/1", n_strobe - s, bus.halted); end
    redirect(64'd0);
    n_chk++; if ({bus.halted, bus.mem_rd_en, bus.mem_addr} !== {2'b01, 64'd0}) begin n_err++; $display("FAIL halt_restart: got %b%b/%h want 01/0", bus.halted, bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if ({n, bus.icode, bus.valP} !== {32'd11, 4'h3, 64'd10}) begin n_err++; $display("FAIL halt_refetch: got %0d/%h/%h want 11/3/a", n, bus.icode, bus.valP); end
  endtask

  task automatic test_load_vs_accept();
    int n;
    redirect(64'd5);
    wait_valid(n);
    bus.out_ready = 1'b1;
    bus.pc_load   = 1'b1;
    bus.load_pc   = 64'h29;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.pc_load   = 1'b0;
    n_chk++; if ({bus.halted, bus.out_valid, bus.mem_rd_en, bus.mem_addr} !== {3'b001, 64'h29}) begin
      n_err++; $display("FAIL load_wins: got %b%b%b/%h want 001/29", bus.halted, bus.out_valid, bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if ({n, bus.icode, bus.rA, bus.rB} !== {32'd3, 12'h623}) begin n_err++; $display("FAIL load_wins_fetch: got %0d/%h%h%h want 3/623", n, bus.icode, bus.rA, bus.rB); end
  endtask

  task automatic test_abort();
    int n;
    redirect(64'd0);
    repeat (3) @(negedge clk);
    n_chk++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 64'd3}) begin n_err++; $display("FAIL abort_byte3: got %b/%h want 1/3", bus.mem_rd_en, bus.mem_addr); end
    redirect(64'h29);
    n_chk++; if ({bus.out_valid, bus.mem_rd_en, bus.mem_addr} !== {2'b01, 64'h29}) begin n_err++; $display("FAIL abort_redirect: got %b%b/%h want 01/29", bus.out_valid, bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if (n !== 3) begin n_err++; $display("FAIL abort_latency: got %0d want 3", n); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP} !== {16'h6023, 64'h0, 64'h2B}) begin
      n_err++; $display("FAIL abort_fields: got %h%h%h%h/%h/%h want 6023/0/2b", bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP); end
  endtask

  task automatic test_addr_error();
    int n;
    int o;
    o = n_oor;
    seen_2047 = 1'b0;
    redirect(64'd2046);
    n_chk++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 64'd2046}) begin n_err++; $display("FAIL err_first_issue: got %b/%h want 1/7fe", bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if ((n > 0) !== 1'b1) begin n_err++; $display("FAIL err_valid_timeout: got %0d want >0", n); end
    n_chk++; if ({bus.imem_error, bus.instr_invalid} !== 2'b10) begin n_err++; $display("FAIL err_flags: got %b want 10", {bus.imem_error, bus.instr_invalid}); end
    n_chk++; if ({bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP} !== {16'h00FF, 64'h0, 64'd2046}) begin
      n_err++; $display("FAIL err_fields: got %h%h%h%h/%h/%h want 00ff/0/7fe", bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP); end
    n_chk++; if ({seen_2047, n_oor - o} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL err_issue_range: got seen2047=%b oor=%0d want 1/0", seen_2047, n_oor - o); end
    accept();
    n_chk++; if ({bus.halted, bus.out_valid} !== 2'b10) begin n_err++; $display("FAIL err_halt: got %b want 10", {bus.halted, bus.out_valid}); end
  endtask

  task automatic test_invalid();
    int n;
    redirect(64'h40);
    wait_valid(n);
    n_chk++; if (n !== 2) begin n_err++; $display("FAIL inv_latency: got %0d want 2", n); end
    n_chk++; if ({bus.instr_invalid, bus.imem_error, bus.icode, bus.valP} !== {2'b10, 4'hC, 64'h41}) begin
      n_err++; $display("FAIL inv_fields: got %b%b/%h/%h want 10/c/41", bus.instr_invalid, bus.imem_error, bus.icode, bus.valP); end
    accept();
    n_chk++; if ({bus.halted, bus.mem_rd_en} !== 2'b10) begin n_err++; $display("FAIL inv_halt: got %b want 10", {bus.halted, bus.mem_rd_en}); end
  endtask

  task automatic test_reset_midfetch();
    int n;
    int s;
    redirect(64'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.mem_rd_en, bus.out_valid, bus.halted, bus.rA, bus.rB} !== 11'h0FF) begin
      n_err++; $display("FAIL midreset_async: got %b%b%b/%h%h want 000/ff", bus.mem_rd_en, bus.out_valid, bus.halted, bus.rA, bus.rB); end
    s = n_strobe;
    repeat (3) @(negedge clk);
    n_chk++; if (n_strobe !== s) begin n_err++; $display("FAIL midreset_strobes: got %0d want 0", n_strobe - s); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL midreset_restart: got %b/%h want 1/0", bus.mem_rd_en, bus.mem_addr); end
    wait_valid(n);
    n_chk++; if ({n, bus.icode, bus.valP} !== {32'd11, 4'h3, 64'd10}) begin n_err++; $display("FAIL midreset_fetch: got %0d/%h/%h want 11/3/a", n, bus.icode, bus.valP); end
  endtask

  initial begin
    bus.pc_load   = 1'b0;
    bus.load_pc   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    // irmovq $0x123, %rsp at 0
    mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h23; mem[3] = 8'h01;
    // jmp 0x100 at 0x20, addq %rdx,%rbx at 0x29, nop at 0x2B
    mem[32'h20] = 8'h70; mem[32'h22] = 8'h01;
    mem[32'h29] = 8'h60; mem[32'h2A] = 8'h23;
    mem[32'h2B] = 8'h10; mem[32'h2C] = 8'h60;
    mem[32'h40] = 8'hC0; mem[32'h41] = 8'h23;
    mem[2046]   = 8'h30; mem[2047]   = 8'hF4;

    test_reset();
    test_irmovq();
    test_jmp_addq();
    test_backpressure();
    test_halt();
    test_load_vs_accept();
    test_abort();
    test_addr_error();
    test_invalid();
    test_reset_midfetch();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequencer that fetches one Y86-64 instruction at a time from a byte-wide synchronous instruction memory, one byte per cycle.
- Assembles icode, ifun, rA, rB and valC (little-endian) and computes valP.
- Presents the decoded fields to the decode stage with a valid/ready handshake.
- Owns the fetch PC: advances it, accepts redirects from the pipeline, and stops on halt or on a memory or instruction error.

Parameters:
- DATA_WID, 64, width of PC, valC and valP.
- MEM_DEPTH, 2048, number of bytes in instruction memory; valid addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_load  in  1  redirect request; has priority over everything except reset.
- load_pc  in  DATA_WID  redirect target.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  DATA_WID  byte address, valid when mem_rd_en=1.
- mem_rdata  in  8  read data; valid exactly one cycle after mem_rd_en.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  decode stage accepts.
- icode, ifun, rA, rB  out  4 each  instruction fields.
- valC  out  DATA_WID  constant word.
- valP  out  DATA_WID  PC + instruction length.
- instr_invalid  out  1  icode > 4'hB.
- imem_error  out  1  fetch address >= MEM_DEPTH.
- halted  out  1  fetch stopped.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except rA=rB=4'hF.
  - PC=0, state IDLE.
  - Exiting reset: IDLE moves to FETCH on the next clock edge.
- States: IDLE, FETCH, OUT, HALT.
- FETCH, byte counter idx starting at 0:
  - Each cycle, while idx < len and PC+idx < MEM_DEPTH: drive mem_rd_en=1 and mem_addr=PC+idx, then idx++.
  - Byte k arrives on mem_rdata the cycle after it is issued.
  - Before byte 0 arrives, len is treated as 2, so at most byte 1 is issued speculatively.
  - Once byte 0 arrives, len is fixed by icode:
    - 1 byte: 0, 1, 9.
    - 2 bytes: 2, 6, A, B.
    - 9 bytes: 7, 8.
    - 10 bytes: 3, 4, 5.
    - 1 byte: icode > B (sets instr_invalid).
  - Byte 0 supplies icode=[7:4] and ifun=[3:0].
  - Register byte (byte 1 of 2- and 10-byte forms): rA=[7:4], rB=[3:0]. Without a register byte, rA=rB=4'hF.
  - valC byte j (j=0..7):
    - From byte 1+j for icode 7 and 8.
    - From byte 2+j for icode 3, 4 and 5.
    - Otherwise valC=0.
  - A speculative byte 1 received for a 1-byte instruction is discarded.
  - After the last byte is received, go to OUT.
  - Latency: an N-byte instruction reaches out_valid=1 exactly N+1 cycles after entering FETCH (no wait states).
- OUT:
  - out_valid=1; all fields held stable until the handshake.
  - valP = PC + len, modulo 2^DATA_WID.
  - On out_valid & out_ready:
    - If icode=0, instr_invalid=1 or imem_error=1: go to HALT.
    - Otherwise: PC <= valP, go to FETCH.
  - No bubble cycle is inserted between the handshake and the first issue of the next fetch.
- Address error:
  - If PC+idx >= MEM_DEPTH for a byte that is needed, that byte is not issued.
  - Set imem_error=1; all fields become 0 except rA=rB=F; valP=PC.
  - Go to OUT, then to HALT after the handshake.
- HALT:
  - halted=1, mem_rd_en=0, out_valid=0.
  - Leaves HALT only on pc_load.
- pc_load=1 in any state:
  - Next cycle: PC=load_pc, state FETCH, out_valid=0, idx=0.
  - All error and halted flags cleared.
  - Read data still in flight from the aborted fetch is ignored.
  - If pc_load and the handshake occur in the same cycle, pc_load wins; the accepted instruction is still considered consumed.
- Reset mid-fetch: immediate return to the reset values; no memory strobe is issued while rst_n=0.

Test Plan:
- Reset, memory holds 30 F4 at 0 (irmovq, rB=4), valC=0x0000000000000123 at bytes 2..9 → out_valid 11 cycles after entering FETCH: icode=3, ifun=0, rA=F, rB=4, valC=0x123, valP=10.
- Bytes 70 00 01 00 00 00 00 00 00 at PC=0x20 (jmp) → valC=0x100, valP=0x29, rA=rB=F, out_valid after 10 cycles; then bytes 60 23 (addq) → icode=6, rA=2, rB=3, valP=0x2B.
- Hold out_ready=0 for 5 cycles with out_valid=1 → fields and mem_rd_en=0 stable; then out_ready=1 → next fetch strobe issued in the following cycle.
- Byte 00 (halt) at PC=5 → icode=0, valP=6; after the handshake halted=1 and no further mem_rd_en; pc_load with load_pc=0 → fetching restarts at 0.
- PC=2046 with byte 30 → bytes 2046 and 2047 issued, byte 2048 not issued; imem_error=1, valP=2046; then halted.
- Byte C0 → instr_invalid=1, len 1; pc_load asserted during byte 3 of an irmovq fetch → out_valid stays 0, next mem_addr=load_pc, stale mem_rdata ignored.
